// File: rtl/set3_pkg.sv
// -----------------------------------------------------------------------------
// set3_pkg
// Shared constants for the {2^(n+1)-1, 2^n, 2^n-1} residue number system:
// modulus values and binary operand width as functions of the channel base
// width n, plus the chunk counts used when folding a binary operand into the
// m3 and m1 channels. Used by the forward converter, residue adder and
// reverse converter.
// -----------------------------------------------------------------------------
package set3_pkg;

    localparam int N_DEFAULT = 11;

    // Number of chunks a binary operand is split into for each folded channel.
    localparam int M3_CHUNKS = 4;
    localparam int M1_CHUNKS = 3;

    // Binary operand width; the dynamic range m1*m2*m3 always fits below 2^W.
    function automatic int set3_w(input int n);
        return 3 * n + 1;
    endfunction

    function automatic longint set3_m1(input int n);
        return (longint'(1) << (n + 1)) - 1;
    endfunction

    function automatic longint set3_m2(input int n);
        return longint'(1) << n;
    endfunction

    function automatic longint set3_m3(input int n);
        return (longint'(1) << n) - 1;
    endfunction

endpackage

// File: rtl/set3_eac_fold.sv
// -----------------------------------------------------------------------------
// set3_eac_fold
// Adds a (k+1)-bit partial sum and a k-bit addend modulo 2^k-1 using
// end-around carry, and normalises the all-ones code to zero so the result is
// strictly below the modulus.
// Ports:
//   i_sum     in  k+1  partial sum including its carry bit
//   i_addend  in  k    second addend
//   o_res     out k    (i_sum + i_addend) mod (2^k - 1), normalised
// -----------------------------------------------------------------------------
module set3_eac_fold #(
    parameter int k = 4
) (
    input  logic [k:0]   i_sum,
    input  logic [k-1:0] i_addend,
    output logic [k-1:0] o_res
);

    logic [k+1:0] w_total;
    logic [k:0]   w_fold1;
    logic [k-1:0] w_fold2;

    // The raw total can carry two bits past k. The first fold brings it to at
    // most 2^k+2, so the second fold can never overflow k bits.
    assign w_total = {1'b0, i_sum} + {2'b00, i_addend};
    assign w_fold1 = {1'b0, w_total[k-1:0]} + {{(k-1){1'b0}}, w_total[k+1:k]};
    assign w_fold2 = w_fold1[k-1:0] + {{(k-1){1'b0}}, w_fold1[k]};

    // All ones is the second representation of zero in a 2^k-1 channel.
    assign o_res = (&w_fold2) ? '0 : w_fold2;

endmodule

// File: rtl/set3_fwd_conv.sv
// -----------------------------------------------------------------------------
// set3_fwd_conv
// Two-stage pipelined binary-to-residue converter for the moduli set
// {2^(n+1)-1, 2^n, 2^n-1}. Accepts one operand per cycle over valid/ready and
// stalls without loss under backpressure.
// Optional feature macro: SET3_FWD_CONV_SIGNED_EN -- treat in_x as two's
// complement; the m1/m3 residues are taken from |in_x| and negated (bitwise
// complement) when the operand is negative.
// Ports:
//   clk        in  1    rising-edge clock
//   rst        in  1    synchronous active-high reset
//   in_valid   in  1    operand present
//   in_ready   out 1    converter accepts operand this cycle
//   in_x       in  W    binary operand, W = 3n+1
//   out_valid  out 1    residue triple present
//   out_ready  in  1    consumer accepts triple this cycle
//   out1       out n+1  X mod (2^(n+1)-1)
//   out2       out n    X mod 2^n
//   out3       out n    X mod (2^n-1)
// -----------------------------------------------------------------------------
module set3_fwd_conv
    import set3_pkg::*;
#(
    parameter  int n = N_DEFAULT,
    localparam int W = set3_w(n)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n:0]   out1,
    output logic [n-1:0] out2,
    output logic [n-1:0] out3
);

    // Width of the top chunk of each folded channel before zero extension.
    localparam int T3W = W - (M3_CHUNKS - 1) * n;
    localparam int T1W = W - (M1_CHUNKS - 1) * (n + 1);

    logic         r_s1_valid;
    logic [n:0]   r_s3a;
    logic [n:0]   r_s3b;
    logic [n+1:0] r_s1a;
    logic [n:0]   r_d2;
    logic [n-1:0] r_m2;
    logic         r_out_valid;
    logic [n:0]   r_out1;
    logic [n-1:0] r_out2;
    logic [n-1:0] r_out3;

    logic         w_s2_load;
    logic [W-1:0] w_mag;
    logic [n-1:0] w_c0, w_c1, w_c2, w_c3;
    logic [n:0]   w_d0, w_d1, w_d2;
    logic [n-1:0] w_s3b_f;
    logic [n-1:0] w_res3;
    logic [n:0]   w_res1;
    logic [n:0]   w_out1;
    logic [n-1:0] w_out3;

    // The output register loads when empty or draining; stage 1 loads
    // whenever the stage ahead can take its contents.
    assign w_s2_load = !r_out_valid | out_ready;
    assign in_ready  = !r_s1_valid | w_s2_load;

`ifdef SET3_FWD_CONV_SIGNED_EN
    logic w_sign;
    logic r_sign;

    assign w_sign = in_x[W-1];
    assign w_mag  = w_sign ? (~in_x + {{(W-1){1'b0}}, 1'b1}) : in_x;
`else
    assign w_mag  = in_x;
`endif

    // Chunking for the two folded channels.
    assign w_c0 = w_mag[n-1:0];
    assign w_c1 = w_mag[2*n-1:n];
    assign w_c2 = w_mag[3*n-1:2*n];
    assign w_c3 = {{(n-T3W){1'b0}}, w_mag[W-1 -: T3W]};
    assign w_d0 = w_mag[n:0];
    assign w_d1 = w_mag[2*n+1:n+1];
    assign w_d2 = {{(n+1-T1W){1'b0}}, w_mag[W-1 -: T1W]};

    // c2+c3 is at most 2^n because c3 is a single bit, so one fold of its
    // carry fits in n bits before the final end-around addition.
    assign w_s3b_f = r_s3b[n-1:0] + {{(n-1){1'b0}}, r_s3b[n]};

    set3_eac_fold #(.k(n)) u_fold3 (
        .i_sum    (r_s3a),
        .i_addend (w_s3b_f),
        .o_res    (w_res3)
    );

    set3_eac_fold #(.k(n+1)) u_fold1 (
        .i_sum    (r_s1a),
        .i_addend (r_d2),
        .o_res    (w_res1)
    );

`ifdef SET3_FWD_CONV_SIGNED_EN
    // Negation modulo 2^k-1 is a bitwise complement; a zero residue stays zero.
    assign w_out1 = (r_sign && (w_res1 != '0)) ? ~w_res1 : w_res1;
    assign w_out3 = (r_sign && (w_res3 != '0)) ? ~w_res3 : w_res3;

    // Sign travels alongside the stage-1 partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (in_ready && in_valid) begin
            r_sign <= w_sign;
        end
    end
`else
    assign w_out1 = w_res1;
    assign w_out3 = w_res3;
`endif

    // Stage 1 holds pairwise chunk sums with their carries; stage 2 holds the
    // final folded residues. Data only moves when the valid bit moves with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s3a       <= '0;
            r_s3b       <= '0;
            r_s1a       <= '0;
            r_d2        <= '0;
            r_m2        <= '0;
            r_out_valid <= 1'b0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_out3      <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s3a <= {1'b0, w_c0} + {1'b0, w_c1};
                    r_s3b <= {1'b0, w_c2} + {1'b0, w_c3};
                    r_s1a <= {1'b0, w_d0} + {1'b0, w_d1};
                    r_d2  <= w_d2;
                    r_m2  <= in_x[n-1:0];
                end
            end
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out1 <= w_out1;
                    r_out2 <= r_m2;
                    r_out3 <= w_out3;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out1      = r_out1;
    assign out2      = r_out2;
    assign out3      = r_out3;

endmodule

// File: tb/tb_set3_fwd_conv.sv
// -----------------------------------------------------------------------------
// tb_set3_fwd_conv
// Directed bench for set3_fwd_conv at n=4 (moduli 31, 16, 15; W=13).
// -----------------------------------------------------------------------------
module tb_set3_fwd_conv;

    localparam int N = 4;
    localparam int W = 3 * N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out1;
    logic [N-1:0] out2;
    logic [N-1:0] out3;

    int checks   = 0;
    int failures = 0;

    logic         monEn = 1'b0;
    logic [W-1:0] seen[$];

    set3_fwd_conv #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    always #5 clk = ~clk;

    // Record every triple that actually transfers to the consumer.
    always @(negedge clk) begin
        if (monEn && out_valid && out_ready) begin
            seen.push_back({out1, out2, out3});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, out1, out2, out3} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected 0", {out_valid, out1, out2, out3});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        in_valid = 1'b1; in_x = '0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_latency_early: got out_valid=%b expected 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out1, out2, out3} !== {1'b1, 13'd0}) begin
            failures++;
            $display("[TB] FAIL zero_result: got %h expected %h", {out_valid, out1, out2, out3}, {1'b1, 13'd0});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_single: got out_valid=%b expected 0", out_valid);
        end
    endtask

    // Stream three operands back to back and expect three consecutive triples.
    task automatic run_stream3(input string name,
                               input logic [W-1:0] x0, input logic [W-1:0] x1, input logic [W-1:0] x2,
                               input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [W-1:0] e2);
        logic [W-1:0] xs[3];
        logic [W-1:0] ex[3];
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            if (i < 3) in_x = xs[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s_in_ready[%0d]: got %b expected 1", name, i, in_ready);
            end
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if ({out_valid, out1, out2, out3} !== {1'b1, ex[i-1]}) begin
                    failures++;
                    $display("[TB] FAIL %s_out[%0d]: got v=%b (%0d,%0d,%0d) expected v=1 (%0d,%0d,%0d)",
                             name, i-1, out_valid, out1, out2, out3,
                             ex[i-1][3*N:2*N], ex[i-1][2*N-1:N], ex[i-1][N-1:0]);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s_idle[%0d]: got out_valid=%b expected 0", name, i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stream;
        run_stream3("stream", 13'd100, 13'd7439, 13'd8191,
                    {5'd7, 4'd4, 4'd10}, {5'd30, 4'd15, 4'd14}, {5'd7, 4'd15, 4'd1});
    endtask

    task automatic test_normalise;
        // 31 -> m1 residue 0 (not 31); 15 -> m3 residue 0 (not 15).
        run_stream3("normalise", 13'd31, 13'd15, 13'd0,
                    {5'd0, 4'd15, 4'd1}, {5'd15, 4'd15, 4'd0}, 13'd0);
    endtask

    task automatic test_back_to_back_stall;
        logic [W-1:0] xs[4];
        logic [W-1:0] ex[4];
        int idx;
        logic acc;
        xs[0] = 13'd10; xs[1] = 13'd20; xs[2] = 13'd30; xs[3] = 13'd40;
        ex[0] = {5'd10, 4'd10, 4'd10};
        ex[1] = {5'd20, 4'd4,  4'd5};
        ex[2] = {5'd30, 4'd14, 4'd0};
        ex[3] = {5'd9,  4'd8,  4'd10};
        idx = 0;
        seen.delete();
        monEn = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) in_x = xs[idx];
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        checks++;
        if (idx !== 2) begin
            failures++;
            $display("[TB] FAIL stall_accepts: got %0d expected 2", idx);
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL stall_flags: got in_ready=%b out_valid=%b expected in_ready=0 out_valid=1", in_ready, out_valid);
        end
        checks++;
        if ({out1, out2, out3} !== ex[0]) begin
            failures++;
            $display("[TB] FAIL stall_hold: got %h expected %h", {out1, out2, out3}, ex[0]);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 20 && seen.size() < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) in_x = xs[idx];
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (seen.size() != 4) begin
            failures++;
            $display("[TB] FAIL stall_count: got %0d expected 4", seen.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) begin
                checks++;
                if (seen[i] !== ex[i]) begin
                    failures++;
                    $display("[TB] FAIL stall_order[%0d]: got %h expected %h", i, seen[i], ex[i]);
                end
            end
        end
        monEn = 1'b0;
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 13'd50;
        tick();
        in_x = 13'd60;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL full_pipe: got out_valid=%b in_ready=%b expected 1,0", out_valid, in_ready);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midflight_reset: got out_valid=%b expected 0", out_valid);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        seen.delete();
        monEn = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        monEn = 1'b0;
        checks++;
        if (seen.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midflight_leak: got %0d transfers out_valid=%b expected 0,0", seen.size(), out_valid);
        end
    endtask

`ifdef SET3_FWD_CONV_SIGNED_EN
    task automatic test_signed;
        // -1 -> (30,15,14); -100 -> (24,12,5); 100 -> (7,4,10).
        run_stream3("signed", 13'h1FFF, 13'd8092, 13'd100,
                    {5'd30, 4'd15, 4'd14}, {5'd24, 4'd12, 4'd5}, {5'd7, 4'd4, 4'd10});
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] set3_fwd_conv bench start");
        test_reset();
`ifdef SET3_FWD_CONV_SIGNED_EN
        test_signed();
`else
        test_stream();
`endif
        test_normalise();
        test_back_to_back_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
